// File: rtl/dfe_apb_pkg.sv
// Shared types and constants for the DFE APB configuration master.
package dfe_apb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 7;
  localparam int unsigned DEF_PDATA_WIDTH = 32;
  localparam int unsigned DEF_COEFF_WIDTH = 20;
  localparam int unsigned DEF_COMP        = 4;
  localparam int unsigned DEF_LEN_WIDTH   = 8;

  // One-hot component selects on the DFE configuration bus
  localparam logic [DEF_COMP-1:0] SEL_FRAC_DEC = 4'b0001;
  localparam logic [DEF_COMP-1:0] SEL_IIR_2_4  = 4'b0010;
  localparam logic [DEF_COMP-1:0] SEL_IIR_5_1  = 4'b0100;
  localparam logic [DEF_COMP-1:0] SEL_CTRL_CIC = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RDCAP,
    ST_RSP
  } apb_state_e;

endpackage

// File: rtl/dfe_apb_cfg_master_if.sv
// DFE configuration bus (MTRANS/MWRITE/MSELx/MADDR/MWDATA/MRDATA).
interface dfe_apb_cfg_master_if
  import dfe_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned PDATA_WIDTH = DEF_PDATA_WIDTH,
  parameter int unsigned COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int unsigned COMP        = DEF_COMP
);
  logic                   MTRANS;
  logic                   MWRITE;
  logic [COMP-1:0]        MSELx;
  logic [ADDR_WIDTH-1:0]  MADDR;
  logic [COEFF_WIDTH-1:0] MWDATA;
  logic [PDATA_WIDTH-1:0] MRDATA;

  modport master (output MTRANS, MWRITE, MSELx, MADDR, MWDATA, input MRDATA);
  modport slave  (input MTRANS, MWRITE, MSELx, MADDR, MWDATA, output MRDATA);
endinterface

// File: rtl/dfe_apb_beat_ctr.sv
// Burst beat down-counter and bus address incrementer (address wraps modulo 2^ADDR_WIDTH).
module dfe_apb_beat_ctr
  import dfe_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // Load on command acceptance, advance one beat per step
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (load) begin
      cnt_d  = load_len;
      addr_d = load_addr;
    end else if (step) begin
      cnt_d  = cnt_q - LEN_WIDTH'(1);
      addr_d = addr_q + ADDR_WIDTH'(1);
    end
  end

  // Counter and address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == '0);
endmodule

// File: rtl/dfe_apb_cfg_master.sv
// APB-style configuration initiator for the DFE register/coefficient bus.
// Optional command checking (one-hot select, no address overrun) with APB_CMD_CHECK_EN.
module dfe_apb_cfg_master
  import dfe_apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned PDATA_WIDTH = DEF_PDATA_WIDTH,
  parameter int unsigned COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int unsigned COMP        = DEF_COMP,
  parameter int unsigned LEN_WIDTH   = DEF_LEN_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [COMP-1:0]        cmd_sel,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic                   wdata_valid,
  output logic                   wdata_ready,
  input  logic [COEFF_WIDTH-1:0] wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PDATA_WIDTH-1:0] rsp_data,
  output logic                   rsp_last,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   done,
  dfe_apb_cfg_master_if.master   bus
);
  apb_state_e             state_q, state_d;
  logic                   mtrans_q, mtrans_d;
  logic                   mwrite_q, mwrite_d;
  logic [COMP-1:0]        msel_q, msel_d;
  logic [COEFF_WIDTH-1:0] mwdata_q, mwdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_last_q, rsp_last_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [PDATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                   done_q, done_d;
  logic                   ctr_load, ctr_step, ctr_last;
  logic [ADDR_WIDTH-1:0]  maddr;
  logic                   cmd_reject;

`ifdef APB_CMD_CHECK_EN
  localparam int unsigned SUM_W = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
  logic [SUM_W-1:0] end_addr;
  assign end_addr   = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
  assign cmd_reject = !$onehot(cmd_sel) || (end_addr > SUM_W'((1 << ADDR_WIDTH) - 1));
`else
  assign cmd_reject = 1'b0;
`endif

  dfe_apb_beat_ctr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_beat_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ctr_load),
    .load_addr (cmd_addr),
    .load_len  (cmd_len),
    .step      (ctr_step),
    .addr      (maddr),
    .last      (ctr_last)
  );

  // Next-state, bus and response logic
  always_comb begin
    state_d     = state_q;
    mtrans_d    = 1'b0;
    mwrite_d    = mwrite_q;
    msel_d      = msel_q;
    mwdata_d    = mwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    done_d      = 1'b0;
    ctr_load    = 1'b0;
    ctr_step    = 1'b0;
    wdata_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_reject) begin
            // Rejected command skips the bus entirely and answers with one error beat
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_last_d  = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d  = ST_SETUP;
            msel_d   = cmd_sel;
            mwrite_d = cmd_write;
            ctr_load = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (!mwrite_q) begin
          state_d  = ST_ACCESS;
          mtrans_d = 1'b1;
        end else begin
          wdata_ready = 1'b1;
          if (wdata_valid) begin
            mwdata_d = wdata;
            state_d  = ST_ACCESS;
            mtrans_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (!mwrite_q) begin
          state_d = ST_RDCAP;
        end else if (!ctr_last) begin
          ctr_step = 1'b1;
          state_d  = ST_SETUP;
        end else begin
          done_d   = 1'b1;
          msel_d   = '0;
          mwrite_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_RDCAP: begin
        rsp_data_d  = bus.MRDATA;
        rsp_valid_d = 1'b1;
        rsp_last_d  = ctr_last;
        rsp_err_d   = 1'b0;
        state_d     = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          rsp_err_d   = 1'b0;
          if (rsp_err_q || ctr_last) begin
            done_d   = 1'b1;
            msel_d   = '0;
            mwrite_d = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            ctr_step = 1'b1;
            state_d  = ST_SETUP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mtrans_q    <= 1'b0;
      mwrite_q    <= 1'b0;
      msel_q      <= '0;
      mwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mtrans_q    <= mtrans_d;
      mwrite_q    <= mwrite_d;
      msel_q      <= msel_d;
      mwdata_q    <= mwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_last   = rsp_last_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign bus.MTRANS = mtrans_q;
  assign bus.MWRITE = mwrite_q;
  assign bus.MSELx  = msel_q;
  assign bus.MADDR  = maddr;
  assign bus.MWDATA = mwdata_q;
endmodule
